// File: rtl/matrix_mem_server_if.sv
// Request/response bus between the GSIM matrix reader and the memory server,
// plus the host row-load port.
interface matrix_mem_server_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 256
);
  logic              load_wen;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              mem_rreq;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rrdy;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_dout_vld;

  modport master (
    output load_wen, load_addr, load_data, mem_rreq, mem_addr,
    input  mem_rrdy, mem_dout, mem_dout_vld
  );

  modport slave (
    input  load_wen, load_addr, load_data, mem_rreq, mem_addr,
    output mem_rrdy, mem_dout, mem_dout_vld
  );
endinterface

// File: rtl/matrix_mem_server.sv
// Row-memory responder: fixed-latency read pipeline with a repeating ready
// throttle pattern and a host load port.
module matrix_mem_server #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 256,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 2,
  parameter logic [7:0]  STALL_MASK = 8'h47
) (
  input  logic                clk,
  input  logic                reset,
  matrix_mem_server_if.slave  bus,
  output logic [15:0]         rd_cnt
);

  localparam int unsigned SLOT_W = 3;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [SLOT_W-1:0] slot;
  logic              rrdy_q;
  logic [LATENCY-1:0] vld_pipe;
  logic [DATA_W-1:0]  data_pipe [LATENCY];
  logic               accept_c;
  logic [DATA_W-1:0]  rd_data_c;

  assign accept_c  = bus.mem_rreq && rrdy_q;
  assign rd_data_c = mem[bus.mem_addr];

  // Row storage: never cleared, writes blocked while in reset
  always_ff @(posedge clk) begin
    if (!reset && bus.load_wen) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  // Read pipeline; invalid stages carry zero so the output is zero when not valid
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) begin
        data_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0]  <= accept_c;
      data_pipe[0] <= accept_c ? rd_data_c : '0;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        data_pipe[i] <= data_pipe[i-1];
      end
    end
  end

  // Throttle: slot walks the 8-entry stall mask, ready is registered from it
  always_ff @(posedge clk) begin
    if (reset) begin
      slot   <= '0;
      rrdy_q <= 1'b1;
    end else begin
      rrdy_q <= ~STALL_MASK[slot];
      slot   <= slot + SLOT_W'(1);
    end
  end

  // Saturating accept counter
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
    end else if (accept_c && (rd_cnt != 16'hFFFF)) begin
      rd_cnt <= rd_cnt + 16'd1;
    end
  end

  assign bus.mem_rrdy     = rrdy_q;
  assign bus.mem_dout_vld = vld_pipe[LATENCY-1];
  assign bus.mem_dout     = data_pipe[LATENCY-1];

endmodule

// File: tb/tb_matrix_mem_server.sv
// Bench for matrix_mem_server: four instances (latency/mask variants) share one
// stimulus stream and are checked every cycle against a cycle-count model.
module tb_matrix_mem_server;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned NDUT   = 4;
  localparam int unsigned LATS  [NDUT] = '{2, 2, 1, 4};
  localparam logic [7:0]  MASKS [NDUT] = '{8'h00, 8'h47, 8'h00, 8'h00};

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              load_wen  = 1'b0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic              rreq      = 1'b0;
  logic [ADDR_W-1:0] raddr     = '0;

  logic              rdy_a  [NDUT];
  logic              vld_a  [NDUT];
  logic [DATA_W-1:0] dout_a [NDUT];
  logic [15:0]       cnt_a  [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    matrix_mem_server_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    matrix_mem_server #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
      .LATENCY(LATS[g]), .STALL_MASK(MASKS[g])
    ) u_dut (
      .clk(clk), .reset(reset), .bus(bus), .rd_cnt(cnt_a[g])
    );
    assign bus.load_wen  = load_wen;
    assign bus.load_addr = load_addr;
    assign bus.load_data = load_data;
    assign bus.mem_rreq  = rreq;
    assign bus.mem_addr  = raddr;
    assign rdy_a[g]  = bus.mem_rrdy;
    assign vld_a[g]  = bus.mem_dout_vld;
    assign dout_a[g] = bus.mem_dout;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input int idx, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[dut%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  // Model: ready is a function of cycles since reset; each accept schedules
  // its row into a ring slot LATENCY-1 edges ahead of the accepting edge.
  logic [DATA_W-1:0] mem_m [DEPTH];
  int                n_m = 0;
  bit                model_on = 1'b0;
  logic [15:0]       cnt_m [NDUT];
  logic              ev [NDUT][16];
  logic [DATA_W-1:0] ed [NDUT][16];

  function automatic logic rdy_of(input int g, input int n);
    if (n == 0) return 1'b1;
    return ~MASKS[g][(n - 1) % 8];
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      model_on <= 1'b1;
      n_m <= 0;
      for (int g = 0; g < NDUT; g++) begin
        cnt_m[g] <= '0;
        for (int k = 0; k < 16; k++) ev[g][k] <= 1'b0;
      end
    end else begin
      for (int g = 0; g < NDUT; g++) begin
        ev[g][(n_m + int'(LATS[g])) % 16] <= rreq && rdy_of(g, n_m);
        ed[g][(n_m + int'(LATS[g])) % 16] <= mem_m[raddr];
        if (rreq && rdy_of(g, n_m) && (cnt_m[g] != 16'hFFFF)) cnt_m[g] <= cnt_m[g] + 16'd1;
      end
      if (load_wen) mem_m[load_addr] <= load_data;
      n_m <= n_m + 1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int g = 0; g < NDUT; g++) begin
        chk("rdy",  g, DATA_W'(rdy_a[g]), DATA_W'(rdy_of(g, n_m)));
        chk("vld",  g, DATA_W'(vld_a[g]), DATA_W'(ev[g][n_m % 16]));
        chk("dout", g, dout_a[g], ev[g][n_m % 16] ? ed[g][n_m % 16] : '0);
        chk("cnt",  g, DATA_W'(cnt_a[g]), DATA_W'(cnt_m[g]));
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load_row(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    load_wen  = 1'b1;
    load_addr = a;
    load_data = d;
    @(negedge clk);
    load_wen  = 1'b0;
  endtask

  logic [DATA_W-1:0] row_a, row_b, row_x, row_y;
  int pulses;

  initial begin
    row_a = {8{32'hAAAA_0005}};
    row_b = {8{32'hBBBB_0006}};
    row_x = {8{32'h1111_0003}};
    row_y = {8{32'h2222_0003}};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rdy",  0, DATA_W'(rdy_a[0]), DATA_W'(1'b1));
    chk("reset_vld",  0, DATA_W'(vld_a[0]), '0);
    chk("reset_dout", 0, dout_a[0], '0);
    chk("reset_cnt",  0, DATA_W'(cnt_a[0]), '0);
    reset = 1'b0;

    load_row(10'd5, row_a);
    load_row(10'd6, row_b);
    load_row(10'd3, row_x);
    for (int i = 16; i < 32; i++) load_row(ADDR_W'(i), {8{32'(i) * 32'h0101_0101}});
    @(negedge clk);

    // Load/read: requests 5 then 6 on consecutive edges
    rreq = 1'b1; raddr = 10'd5;
    @(negedge clk);
    chk("l1_first", 2, dout_a[2], row_a);
    raddr = 10'd6;
    @(negedge clk);
    rreq = 1'b0;
    chk("l2_first",  0, dout_a[0], row_a);
    chk("l1_second", 2, dout_a[2], row_b);
    @(negedge clk);
    chk("l2_second", 0, dout_a[0], row_b);
    chk("l1_idle",   2, DATA_W'(vld_a[2]), '0);
    @(negedge clk);
    chk("l4_first", 3, dout_a[3], row_a);
    @(negedge clk);
    chk("l4_second", 3, dout_a[3], row_b);
    chk("l2_cnt",    0, DATA_W'(cnt_a[0]), DATA_W'(16'd2));

    // Throttle: reset to realign the slot pattern, then request every cycle
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      rreq = 1'b1; raddr = ADDR_W'(16 + i);
      @(negedge clk);
      if (vld_a[1]) pulses++;
    end
    rreq = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (vld_a[1]) pulses++;
    end
    chk("thr_cnt",    1, DATA_W'(cnt_a[1]), DATA_W'(16'd8));
    chk("thr_pulses", 1, DATA_W'(pulses), DATA_W'(8));
    chk("nothr_cnt",  0, DATA_W'(cnt_a[0]), DATA_W'(16'd16));

    // Collision: read and write row 3 on the same edge returns the old row
    load_wen = 1'b1; load_addr = 10'd3; load_data = row_y;
    rreq = 1'b1; raddr = 10'd3;
    @(negedge clk);
    load_wen = 1'b0;
    chk("coll_old", 2, dout_a[2], row_x);
    @(negedge clk);
    rreq = 1'b0;
    chk("coll_new", 2, dout_a[2], row_y);
    repeat (6) @(negedge clk);

    // Reset with reads in flight
    rreq = 1'b1; raddr = 10'd5;
    @(negedge clk);
    raddr = 10'd6;
    @(negedge clk);
    rreq = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_vld",  3, DATA_W'(vld_a[3]), '0);
    chk("rst_dout", 3, dout_a[3], '0);
    chk("rst_cnt",  3, DATA_W'(cnt_a[3]), '0);
    chk("rst_rdy",  3, DATA_W'(rdy_a[3]), DATA_W'(1'b1));
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (vld_a[3] || vld_a[0]) pulses++;
    end
    chk("rst_no_pulse", 3, DATA_W'(pulses), '0);
    rreq = 1'b1; raddr = 10'd5;
    @(negedge clk);
    rreq = 1'b0;
    @(negedge clk);
    chk("rst_keep_mem", 0, dout_a[0], row_a);

    // Saturation
    rreq = 1'b1; raddr = 10'd5;
    repeat (65540) @(negedge clk);
    rreq = 1'b0;
    chk("sat_cnt_l2", 0, DATA_W'(cnt_a[0]), DATA_W'(16'hFFFF));
    chk("sat_cnt_l1", 2, DATA_W'(cnt_a[2]), DATA_W'(16'hFFFF));
    repeat (6) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/matrix_mem_server.md
# matrix_mem_server

Memory-side responder for the GSIM matrix read interface. It holds the packed matrix/vector rows (1024 × 256-bit) and answers GSIM's `o_mem_rreq`/`o_mem_addr` requests on `i_mem_rrdy`/`i_mem_dout`/`i_mem_dout_vld`. The answer comes back with a fixed, parameterised latency and a repeating, parameterised ready-throttle pattern. A separate host load port fills the array before or during a run.

## Interface

**Parameters**
- `ADDR_W`, default 10: row address width.
- `DATA_W`, default 256: row width (16 × 16-bit entries).
- `DEPTH`, default 1024: number of rows.
- `LATENCY`, default 2: cycles from accepted request to `o_mem_dout_vld`. Legal range 1..4.
- `STALL_MASK`, default 8'h47: bit k set means ready is deasserted in throttle slot k.

**Ports**
- `i_clk`, in, 1: clock.
- `i_reset`, in, 1: reset. Synchronous, active-high.
- `i_load_wen`, in, 1: host row write enable.
- `i_load_addr`, in, ADDR_W: host row write address.
- `i_load_data`, in, DATA_W: host row write data.
- `i_mem_rreq`, in, 1: read request from GSIM.
- `i_mem_addr`, in, ADDR_W: read row address from GSIM.
- `o_mem_rrdy`, out, 1: request accept ready.
- `o_mem_dout`, out, DATA_W: read data. Zero whenever not valid.
- `o_mem_dout_vld`, out, 1: read data valid, one cycle per accepted request.
- `o_rd_cnt`, out, 16: number of accepted requests, saturating.

## Operation

**Storage**
- DEPTH × DATA_W register array. Contents are not cleared by reset.
- Write: on an edge with `i_load_wen`=1, `mem[i_load_addr] <= i_load_data`.

**Accept**
- A request is accepted on an edge where `i_mem_rreq && o_mem_rrdy`.
- A request with `o_mem_rrdy`=0 is ignored. Nothing is queued; the requester must hold or reissue.
- Accepted requests increment `o_rd_cnt`. It saturates at 16'hFFFF.

**Read pipeline**
- At accept, `mem[i_mem_addr]` is captured into stage 1 together with a valid bit.
- The valid bit and data shift through LATENCY stages; the last stage drives the outputs.
- The pipeline never stalls. Results return in request order.
- One request can be accepted per cycle, so back-to-back accepts give back-to-back valid cycles.
- Read/write collision: a read accepted on the same edge as a load write to the same address returns the OLD data.

**Throttle generator**
- 3-bit slot counter `slot`. Reset value: `slot`=0, `o_mem_rrdy`=1.
- On each edge without reset: `o_mem_rrdy <= ~STALL_MASK[slot]`, then `slot <= slot+1`, wrapping 7→0.
- `o_mem_rrdy` is registered and independent of `i_mem_rreq`.
- STALL_MASK=8'h00 means always ready.
- STALL_MASK=8'hFF means ready only in the first cycle after reset.

**Reset**
- Synchronous. Affects only control state.
- Clears all pipeline valid and data stages, `o_rd_cnt`, and `slot`.
- Reset values: `o_mem_dout_vld`=0, `o_mem_dout`=0, `o_rd_cnt`=0, `o_mem_rrdy`=1.
- Reset mid-operation discards in-flight reads; no valid is produced for them.
- `i_load_wen` is ignored while `i_reset`=1.

## Timing

- Accept at edge t → `o_mem_dout_vld`=1 and data on `o_mem_dout` during the cycle after edge t+LATENCY−1. With LATENCY=2, valid appears one full cycle after the accept cycle.
- All outputs are registered. There are no combinational input→output paths.
- With the default mask, `o_mem_rrdy` per cycle after reset release, starting at cycle 0: 1, then repeating 0,0,0,1,1,1,0,1.
- `o_mem_dout` is forced to zero in every cycle where `o_mem_dout_vld`=0.

## Test plan

1. **Load/read.** Load row 5=A, row 6=B. Hold STALL_MASK=0 and issue requests 5 then 6 on consecutive edges → vld high 2 consecutive cycles, LATENCY after each accept, data A then B, `o_rd_cnt`=2.
2. **Throttle.** Default mask, `i_mem_rreq` held high for 16 cycles with incrementing address → accepts occur only in ready cycles (8 of 16 after cycle 0 pattern). Exactly that many valid pulses, in address order. No pulse for stalled cycles.
3. **Collision.** Row 3=X. On the same edge, load row 3=Y and accept a read of 3 → returned X. A read of 3 on the next cycle → Y.
4. **Reset mid-flight.** Accept 2 reads, then assert reset on the next edge → no vld afterwards. `o_rd_cnt`=0, `o_mem_rrdy`=1, `o_mem_dout`=0. Array contents preserved (a later read of row 5 still returns A).
5. **Saturation / latency sweep.** Force 65540 accepts → `o_rd_cnt`=16'hFFFF. Repeat test 1 with LATENCY=1 and LATENCY=4 → valid offset shifts accordingly.
6. **End-to-end.** Connect GSIM with matrix_num=16 and the default mask → GSIM completes and its x outputs match golden0.
